// File: rtl/rand_range_sampler_pkg.sv
// Shared types and helpers for the unbiased range sampler.
package rand_pkg;

  localparam int RAND_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    RESEED
  } state_t;

  // Smallest all-ones mask covering n-1; n=0 wraps to 0xFF (256 outcomes).
  function automatic logic [RAND_W-1:0] mask_for_range(input logic [RAND_W-1:0] n);
    logic [RAND_W-1:0] m;
    m = n - 8'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    return m;
  endfunction

endpackage

// File: rtl/rand_range_sampler_fifo.sv
// Small synchronous FIFO with flush; head is combinational from storage.
module rand_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (fill == '0);
  assign full    = (fill == FW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

endmodule

// File: rtl/rand_range_sampler.sv
// Maps the LFSR stream into [0, N-1] by mask-and-reject, buffers accepted
// samples, and requests a reseed when the LFSR sits at zero too long.
module rand_range_sampler
  import rand_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int STUCK_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RAND_W-1:0]          rand_num,
  input  logic [RAND_W-1:0]          range_cfg,
  input  logic                       cfg_load,
  input  logic                       enable,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RAND_W-1:0]          out_data,
  output logic                       reseed_req,
  output logic [15:0]                reject_cnt,
  output logic [$clog2(DEPTH+1)-1:0] fill
);

  localparam int SW = $clog2(STUCK_LIMIT+1);

  state_t            state;
  logic [RAND_W-1:0] range_q;
  logic [RAND_W-1:0] mask_q;
  logic [SW-1:0]     stuck_q;
  logic [RAND_W-1:0] cand;
  logic              sampling;
  logic              is_zero;
  logic              accept;
  logic              reject;
  logic              stuck_hit;
  logic              pop;
  logic              push;
  logic              full;
  logic              empty;

  assign cand      = rand_num & mask_q;
  assign sampling  = (state == RUN) && enable && !cfg_load;
  assign is_zero   = (rand_num == '0);
  assign accept    = sampling && !is_zero && ((range_q == '0) || (cand < range_q));
  assign reject    = sampling && !is_zero && (range_q != '0) && (cand >= range_q);
  assign stuck_hit = sampling && is_zero && (stuck_q == SW'(STUCK_LIMIT-1));
  assign pop       = !empty && out_ready && !cfg_load;
  assign push      = accept && (!full || pop);
  assign out_valid = !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      range_q    <= '0;
      mask_q     <= 8'hFF;
      stuck_q    <= '0;
      reject_cnt <= '0;
      reseed_req <= 1'b0;
    end else begin
      reseed_req <= 1'b0;
      if (cfg_load) begin
        range_q    <= range_cfg;
        mask_q     <= mask_for_range(range_cfg);
        reject_cnt <= '0;
        stuck_q    <= '0;
        // RESEED is strictly a one-cycle state, even under a config load.
        if (state == RESEED) state <= enable ? RUN : IDLE;
      end else begin
        if (reject && (reject_cnt != 16'hFFFF)) reject_cnt <= reject_cnt + 1'b1;
        case (state)
          IDLE: if (enable) state <= RUN;
          RUN: begin
            if (!enable) begin
              state <= IDLE;
            end else if (stuck_hit) begin
              state      <= RESEED;
              stuck_q    <= '0;
              reseed_req <= 1'b1;
            end else if (is_zero) begin
              stuck_q <= stuck_q + 1'b1;
            end else begin
              stuck_q <= '0;
            end
          end
          RESEED: begin
            stuck_q <= '0;
            state   <= enable ? RUN : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  rand_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RAND_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (cfg_load),
    .din   (cand),
    .fill  (fill),
    .full  (full),
    .empty (empty),
    .head  (out_data)
  );

endmodule

// File: tb/tb_rand_range_sampler.sv
// Scoreboard bench for rand_range_sampler against a cycle-level behavioural model.
module tb_rand_range_sampler;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_RESEED = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rand_num = '0;
  logic [7:0] range_cfg = '0;
  logic       cfg_load = 1'b0;
  logic       enable = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       reseed_req;
  logic [15:0] reject_cnt;
  logic [$clog2(DEPTH+1)-1:0] fill;

  int n_checks = 0;
  int n_fail = 0;

  int m_mode = M_IDLE, m_range = 0, m_mask = 255, m_fill = 0, m_rej = 0, m_stuck = 0;
  int exp_valid = 0, exp_fill = 0, exp_rej = 0, exp_reseed = 0;
  logic [7:0] sb_q[$];

  rand_range_sampler #(.DEPTH(DEPTH), .STUCK_LIMIT(LIMIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .rand_num   (rand_num),
    .range_cfg  (range_cfg),
    .cfg_load   (cfg_load),
    .enable     (enable),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .reseed_req (reseed_req),
    .reject_cnt (reject_cnt),
    .fill       (fill)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Mask grown one bit at a time until it covers every value below n.
  function automatic int bm_mask(input int n);
    int m;
    if (n == 0) return 255;
    m = 0;
    while (m < n - 1) m = m * 2 + 1;
    return m;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_range = 0; m_mask = 255; m_fill = 0; m_rej = 0; m_stuck = 0;
    sb_q.delete();
    exp_valid = 0; exp_fill = 0; exp_rej = 0; exp_reseed = 0;
  endtask

  task automatic model_step(input int rn, input int rc, input bit cl, input bit en, input bit rdy);
    int cand;
    exp_valid  = (m_fill != 0);
    exp_fill   = m_fill;
    exp_rej    = m_rej;
    exp_reseed = (m_mode == M_RESEED);
    if (cl) begin
      m_range = rc; m_mask = bm_mask(rc); m_fill = 0; m_rej = 0; m_stuck = 0;
      sb_q.delete();
      if (m_mode == M_RESEED) m_mode = en ? M_RUN : M_IDLE;
      return;
    end
    if (m_fill != 0 && rdy) m_fill--;
    if (m_mode == M_IDLE || m_mode == M_RESEED) begin
      if (m_mode == M_RESEED) m_stuck = 0;
      m_mode = en ? M_RUN : M_IDLE;
    end else if (!en) begin
      m_mode = M_IDLE;
    end else if (rn == 0) begin
      m_stuck++;
      if (m_stuck == LIMIT) begin
        m_mode = M_RESEED;
        m_stuck = 0;
      end
    end else begin
      m_stuck = 0;
      cand = rn & m_mask;
      if (m_range == 0 || cand < m_range) begin
        if (m_fill < DEPTH) begin
          m_fill++;
          sb_q.push_back(cand[7:0]);
        end
      end else if (m_rej < 65535) begin
        m_rej++;
      end
    end
  endtask

  task automatic cycle(input int rn, input int rc, input bit cl, input bit en, input bit rdy);
    @(negedge clk);
    rst = 1'b0;
    rand_num = rn[7:0]; range_cfg = rc[7:0]; cfg_load = cl; enable = en; out_ready = rdy;
    model_step(rn, rc, cl, en, rdy);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, int'(out_valid), 0);
    check({tag, "_data"}, int'(out_data), 0);
    check({tag, "_reseed"}, int'(reseed_req), 0);
    check({tag, "_rej"}, int'(reject_cnt), 0);
    check({tag, "_fill"}, int'(fill), 0);
  endtask

  // Monitor: compares status against the model and pops the scoreboard on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      check("valid", int'(out_valid), exp_valid);
      check("fill", int'(fill), exp_fill);
      check("reject_cnt", int'(reject_cnt), exp_rej);
      check("reseed_req", int'(reseed_req), exp_reseed);
      if (out_valid && out_ready && !cfg_load && !rst) begin
        if (sb_q.size() == 0) check("data_unexpected", int'(out_data), -1);
        else check("data", int'(out_data), int'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    int burst;
    int rn;
    #3;
    check_reset_outputs("por");

    // Range 6: 3 and 5 accepted, 7 and 6 rejected.
    cycle(0, 6, 1, 0, 0);
    cycle(8'h55, 6, 0, 1, 0);
    cycle(8'h03, 6, 0, 1, 0);
    cycle(8'h07, 6, 0, 1, 0);
    cycle(8'h05, 6, 0, 1, 0);
    cycle(8'h0E, 6, 0, 1, 0);
    cycle(0, 6, 0, 0, 0);
    #4;
    check("t1_fill", int'(fill), 2);
    check("t1_rej", int'(reject_cnt), 2);
    repeat (3) cycle(0, 6, 0, 0, 1);

    // Range 256: overflow drops, then push+pop while full.
    cycle(0, 0, 1, 0, 0);
    cycle(0, 0, 0, 1, 0);
    for (int i = 8'h11; i <= 8'h16; i++) cycle(i, 0, 0, 1, 0);
    cycle(8'h20, 0, 0, 1, 1);
    #4;
    check("t2_full", int'(fill), 4);
    cycle(0, 0, 0, 0, 0);
    #4;
    check("t2_still_full", int'(fill), 4);
    check("t2_rej", int'(reject_cnt), 0);
    repeat (5) cycle(0, 0, 0, 0, 1);

    // Stuck at zero: reseed after 8 zeros, not after 7.
    cycle(0, 0, 0, 1, 1);
    repeat (LIMIT) cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1);
    #4;
    check("t3_reseed_hi", int'(reseed_req), 1);
    cycle(0, 0, 0, 1, 1);
    #4;
    check("t3_reseed_lo", int'(reseed_req), 0);
    cycle(8'h09, 0, 0, 1, 1);
    repeat (LIMIT - 1) cycle(0, 0, 0, 1, 1);
    repeat (3) cycle(8'h01, 0, 0, 1, 1);

    // Flush under a pending handshake; range 1 always yields 0.
    cycle(0, 0, 1, 1, 0);
    repeat (3) cycle(8'h31, 0, 0, 1, 0);
    cycle(0, 1, 1, 1, 1);
    #4;
    check("t4_pre_fill", int'(fill), 3);
    cycle(8'hA5, 1, 0, 1, 0);
    #4;
    check("t4_fill", int'(fill), 0);
    check("t4_valid", int'(out_valid), 0);
    check("t4_rej", int'(reject_cnt), 0);
    cycle(8'h3C, 1, 0, 1, 0);
    repeat (3) cycle(0, 1, 0, 0, 1);

    // Range 255 boundary and reject counter saturation.
    cycle(0, 8'hFF, 1, 1, 1);
    cycle(8'hFE, 8'hFF, 0, 1, 1);
    cycle(8'hFF, 8'hFF, 0, 1, 1);
    cycle(8'h01, 8'hFF, 0, 1, 1);
    #4;
    check("t5_rej1", int'(reject_cnt), 1);
    repeat (65540) cycle(8'hFF, 8'hFF, 0, 1, 1);
    cycle(8'hFF, 8'hFF, 0, 1, 1);
    #4;
    check("t5_sat", int'(reject_cnt), 16'hFFFF);

    // Async reset while FIFO holds 2 and a reseed is in progress.
    cycle(0, 0, 1, 1, 0);
    cycle(8'h40, 0, 0, 1, 0);
    cycle(8'h41, 0, 0, 1, 0);
    repeat (LIMIT) cycle(0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    check("t6_fill_before", int'(fill), 2);
    check("t6_reseed_before", int'(reseed_req), 1);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("t6");
    model_reset();
    cycle(0, 0, 0, 1, 1);
    cycle(8'hFF, 0, 0, 1, 1);
    cycle(8'h80, 0, 0, 1, 1);

    // Randomized traffic with occasional reconfiguration and zero bursts.
    burst = 0;
    for (int i = 0; i < 2000; i++) begin
      if (burst == 0 && $urandom_range(0, 99) == 0) burst = $urandom_range(LIMIT - 2, LIMIT + 3);
      if (burst > 0) begin
        rn = 0;
        burst--;
      end else begin
        rn = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 255));
      end
      cycle(rn,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(1, 20)),
            ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 9) != 0),
            $urandom_range(0, 1) == 1);
    end
    repeat (DEPTH + 2) cycle(0, 0, 0, 0, 1);
    @(negedge clk);
    #5;
    check("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
